cog_segment_accum: RTL
======================

# cog_segment_accum

Parametrised centre-of-gravity accumulator for thresholded line segments ("figures") in the video pipeline, placed between the figure detector and the CoG transmitter. Per figure it accumulates sum(w) and sum(w·coord) with selectable linear or squared pixel weighting. It filters figures by size and queues results in a small FIFO with a valid/ready handshake. Figures may arrive back-to-back with zero idle cycles, and a side-band bus is delay-matched to the result path.

## Interface
- DATA_WIDTH, 8, pixel intensity width
- COORD_WIDTH, 11, start-point width
- MIN_PIX, 3, smallest figure size accepted
- MAX_PIX, 100, largest figure size accepted
- FIFO_DEPTH, 4, result FIFO entries, power of two, ≥2
- SIDE_WIDTH, 3, side-band bus width (end_of_line, end_of_frame, new_frame)

Derived widths:
- CNT_W = $clog2(MAX_PIX+2)
- WW = 2·DATA_WIDTH
- SI_W = WW+CNT_W
- SIC_W = WW+2·CNT_W

Ports:
- i_sys_clk  in  1  clock; single clock domain
- i_sys_reset  in  1  reset, synchronous, active-high
- i_weight_mode  in  1  0 linear w=I, 1 squared w=I²; sampled on the start beat
- i_data_image  in  DATA_WIDTH  pixel intensity
- i_data_valid  in  1  pixel beat qualifier
- i_start_of_fig  in  1  first pixel of figure; qualified by i_data_valid
- i_start_point_value  in  COORD_WIDTH  figure start coordinate; sampled on the start beat
- i_end_of_fig  in  1  last pixel of figure; qualified by i_data_valid; may coincide with start
- o_res_valid  out  1  FIFO head valid
- i_res_ready  in  1  consumer accepts head
- o_res_sum_i  out  SI_W  sum of w
- o_res_sum_i_coord  out  SIC_W  sum of w·coord
- o_res_start_point  out  COORD_WIDTH  start coordinate
- o_res_pixels  out  CNT_W  figure pixel count
- o_drop_cnt  out  16  saturating count of dropped figures
- o_fifo_drop  out  1  sticky: a figure was lost because the FIFO was full
- i_side  in  SIDE_WIDTH  side-band input
- o_side  out  SIDE_WIDTH  i_side delayed by 4 cycles

## Operation
- Coordinates are 0-based within a figure; downstream computes sum_i_coord/sum_i + start_point.
- A figure opens on a start beat and closes on an end beat.
- Valid beats outside an open figure are ignored.
- A start beat arriving while a figure is open aborts the old figure: it is dropped, o_drop_cnt increments, and the new figure opens.
- Pipeline, each stage carrying valid, first and last flags:
  - S1 registers w and coord.
  - S2 registers w·coord.
  - S3 accumulates. On the first flag it loads, never adds, so zero-gap figures need no clear cycle.
- The pixel counter saturates at MAX_PIX+1. Accumulation stops once the count exceeds MAX_PIX, so sums never overflow their widths.
- On the S3 last flag:
  - count in [MIN_PIX, MAX_PIX] and FIFO not full → push.
  - count in range and FIFO full → drop, set o_fifo_drop, increment o_drop_cnt.
  - count out of range → drop, increment o_drop_cnt.
- FIFO:
  - First-word fall-through with registered outputs.
  - Pop when o_res_valid && i_res_ready.
  - Push and pop in the same cycle are both honoured, including when full (pop frees the slot).
- Reset values: all outputs 0; FIFO empty; no figure open; FSM in IDLE.
- Reset mid-figure discards the partial figure without counting it as a drop.
- Input FSM:
  - IDLE → OPEN on a start beat without end.
  - OPEN → IDLE on an end beat.
  - OPEN → OPEN on a start beat (abort path).
  - A start+end beat in IDLE stays in IDLE and emits a 1-pixel figure.

## Timing
- End beat in cycle N → S1 N+1 → S2 N+2 → S3 totals N+3 → FIFO write at N+3 edge → o_res_valid high in N+4 if the FIFO was empty.
- o_side equals i_side from cycle N in cycle N+4, aligned with o_res_valid.
- Throughput: one pixel per cycle; one figure per cycle in the minimum case (1-pixel figures, all dropped when MIN_PIX>1).
- o_res_* stay stable while o_res_valid && !i_res_ready.
- o_drop_cnt holds at 16'hFFFF. o_fifo_drop clears only on reset.

## Structure
- Package cog_pkg holds:
  - weight-mode enum: WM_LINEAR, WM_SQUARED
  - input FSM enum: IDLE, OPEN
  - width functions: cnt_w, si_w, sic_w
  - packed struct cog_result_t {sum_i, sum_i_coord, start_point, pixels}
- Sub-module cog_result_fifo: synchronous FWFT FIFO of cog_result_t with the push/pop rules above.
- The top level contains the input FSM, the 3-stage pipeline, the size filter, the counters and the side-band delay line.

## Test plan
- Squared mode, start 100, pixels 10,20,30 → one result: sum_i=1400, sum_i_coord=2200, start_point=100, pixels=3; o_res_valid 4 cycles after end beat.
- Linear mode, same pixels → sum_i=60, sum_i_coord=80.
- Figures of 2 and 101 pixels → no result, o_drop_cnt=2; a 100-pixel figure of I=255 → pixels=100, no overflow.
- Three 3-pixel figures back-to-back with zero gap, I=1 → three results, each sum_i=3, sum_i_coord=3.
- i_res_ready low, 5 valid figures → 4 queued, o_fifo_drop=1, o_drop_cnt=1; raise ready → 4 pops in order.
- Reset asserted mid-figure, then a fresh 3-pixel figure → only the fresh result appears, o_drop_cnt=0; i_side pulse is seen on o_side exactly 4 cycles later.

Source files
------------

// File: rtl/cog_pkg.sv
// Shared types and width helpers for the centre-of-gravity segment accumulator.
package cog_pkg;

  // Pixel weighting applied to a whole figure, latched on its start beat.
  typedef enum logic {
    WM_LINEAR  = 1'b0,
    WM_SQUARED = 1'b1
  } weight_mode_e;

  // Input framing state: whether a figure is currently open.
  typedef enum logic {
    IDLE = 1'b0,
    OPEN = 1'b1
  } fsm_state_e;

  // Pixel counter width; holds MAX_PIX+1 as the saturated "too large" value.
  function automatic int cnt_w(input int max_pix);
    return $clog2(max_pix + 32'sd2);
  endfunction

  // Width of sum(w): one weight plus one bit per doubling of pixel count.
  function automatic int si_w(input int data_width, input int max_pix);
    return 32'sd2 * data_width + cnt_w(max_pix);
  endfunction

  // Width of sum(w*coord): coordinate adds another counter width.
  function automatic int sic_w(input int data_width, input int max_pix);
    return 32'sd2 * data_width + 32'sd2 * cnt_w(max_pix);
  endfunction

  localparam int DEF_DATA_WIDTH  = 32'sd8;
  localparam int DEF_COORD_WIDTH = 32'sd11;
  localparam int DEF_MAX_PIX     = 32'sd100;

  localparam int DEF_CNT_W = cnt_w(DEF_MAX_PIX);
  localparam int DEF_SI_W  = si_w(DEF_DATA_WIDTH, DEF_MAX_PIX);
  localparam int DEF_SIC_W = sic_w(DEF_DATA_WIDTH, DEF_MAX_PIX);

  // One finished figure as handed to the CoG transmitter.
  typedef struct packed {
    logic [DEF_SI_W-1:0]        sum_i;
    logic [DEF_SIC_W-1:0]       sum_i_coord;
    logic [DEF_COORD_WIDTH-1:0] start_point;
    logic [DEF_CNT_W-1:0]       pixels;
  } cog_result_t;

endpackage

// File: rtl/cog_result_fifo.sv
// First-word fall-through result FIFO with a registered head. A pop frees a
// slot in the same cycle, so a full FIFO still accepts a push alongside a pop.
module cog_result_fifo
  import cog_pkg::*;
#(
  parameter type T     = cog_result_t,
  parameter int  DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     din,
  output logic can_accept,
  input  logic pop_ready,
  output logic out_valid,
  output T     dout
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  T                 mem_r [DEPTH];
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [LVL_W-1:0] level_r;
  logic             valid_r;
  T                 dout_r;

  logic             pop_s;
  logic             do_push_s;
  logic [PTR_W-1:0] next_rd_s;
  logic [LVL_W-1:0] next_level_s;
  T                 head_s;

  assign pop_s      = valid_r & pop_ready;
  assign can_accept = (level_r != LVL_W'(DEPTH)) | pop_s;
  assign do_push_s  = push & can_accept;
  assign out_valid  = valid_r;
  assign dout       = dout_r;

  // Next read pointer, fill level and the entry that becomes the new head.
  always_comb begin
    next_rd_s    = rd_ptr_r;
    next_level_s = level_r;
    head_s       = mem_r[rd_ptr_r];
    if (pop_s) begin
      next_rd_s = rd_ptr_r + PTR_W'(1);
    end else begin
      next_rd_s = rd_ptr_r;
    end
    if (do_push_s && !pop_s) begin
      next_level_s = level_r + LVL_W'(1);
    end else if (!do_push_s && pop_s) begin
      next_level_s = level_r - LVL_W'(1);
    end else begin
      next_level_s = level_r;
    end
    // The incoming word is the head only when it lands in an otherwise empty FIFO.
    if (do_push_s && (wr_ptr_r == next_rd_s)) begin
      head_s = din;
    end else begin
      head_s = mem_r[next_rd_s];
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers, level and the registered head word.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      level_r  <= {LVL_W{1'b0}};
      valid_r  <= 1'b0;
      dout_r   <= '0;
    end else begin
      rd_ptr_r <= next_rd_s;
      level_r  <= next_level_s;
      valid_r  <= (next_level_s != {LVL_W{1'b0}});
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (next_level_s != {LVL_W{1'b0}}) begin
        dout_r <= head_s;
      end
    end
  end

endmodule

// File: rtl/cog_segment_accum.sv
// Centre-of-gravity accumulator: frames figures from the pixel stream, weights
// and accumulates them in a 3-stage pipeline, filters by size and queues results.
module cog_segment_accum
  import cog_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int COORD_WIDTH = 11,
  parameter int MIN_PIX     = 3,
  parameter int MAX_PIX     = 100,
  parameter int FIFO_DEPTH  = 4,
  parameter int SIDE_WIDTH  = 3,
  localparam int CNT_W = cnt_w(MAX_PIX),
  localparam int WW    = 2 * DATA_WIDTH,
  localparam int SI_W  = si_w(DATA_WIDTH, MAX_PIX),
  localparam int SIC_W = sic_w(DATA_WIDTH, MAX_PIX)
) (
  input  logic                   i_sys_clk,
  input  logic                   i_sys_reset,
  input  logic                   i_weight_mode,
  input  logic [DATA_WIDTH-1:0]  i_data_image,
  input  logic                   i_data_valid,
  input  logic                   i_start_of_fig,
  input  logic [COORD_WIDTH-1:0] i_start_point_value,
  input  logic                   i_end_of_fig,
  output logic                   o_res_valid,
  input  logic                   i_res_ready,
  output logic [SI_W-1:0]        o_res_sum_i,
  output logic [SIC_W-1:0]       o_res_sum_i_coord,
  output logic [COORD_WIDTH-1:0] o_res_start_point,
  output logic [CNT_W-1:0]       o_res_pixels,
  output logic [15:0]            o_drop_cnt,
  output logic                   o_fifo_drop,
  input  logic [SIDE_WIDTH-1:0]  i_side,
  output logic [SIDE_WIDTH-1:0]  o_side
);

  typedef struct packed {
    logic [SI_W-1:0]        sum_i;
    logic [SIC_W-1:0]       sum_i_coord;
    logic [COORD_WIDTH-1:0] start_point;
    logic [CNT_W-1:0]       pixels;
  } res_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PIX);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_PIX + 1);
  localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(MIN_PIX);

  // Input framing
  fsm_state_e       state_r, next_state_s;
  weight_mode_e     mode_r, mode_s;
  logic [CNT_W-1:0] coord_r, coord_s;
  logic             pix_s, first_s, last_s, abort_s;
  logic [WW-1:0]    w_s;

  // Pipeline stages
  logic                   v1_r, f1_r, l1_r;
  logic [WW-1:0]          w1_r;
  logic [CNT_W-1:0]       c1_r;
  logic [COORD_WIDTH-1:0] sp1_r;
  logic                   v2_r, f2_r, l2_r;
  logic [WW-1:0]          w2_r;
  logic [SI_W-1:0]        wc2_r;
  logic [COORD_WIDTH-1:0] sp2_r;
  logic                   last3_r;
  logic [SI_W-1:0]        sum_i3_r;
  logic [SIC_W-1:0]       sum_ic3_r;
  logic [CNT_W-1:0]       cnt3_r;
  logic [COORD_WIDTH-1:0] sp3_r;

  // Filter, counters, FIFO
  logic                  in_range_s, push_req_s, s3_drop_s, full_drop_s, can_accept_s;
  logic [1:0]            drop_inc_s;
  logic [16:0]           drop_sum_s;
  logic [15:0]           drop_cnt_r;
  logic                  fifo_drop_r;
  res_t                  res_s, fifo_dout_s;
  logic [SIDE_WIDTH-1:0] side_r [4];

  // Framing decisions for the current beat and the input FSM next state.
  always_comb begin
    next_state_s = state_r;
    pix_s        = 1'b0;
    first_s      = 1'b0;
    last_s       = 1'b0;
    abort_s      = 1'b0;
    mode_s       = mode_r;
    coord_s      = coord_r;
    if (i_data_valid && i_start_of_fig) begin
      pix_s        = 1'b1;
      first_s      = 1'b1;
      last_s       = i_end_of_fig;
      abort_s      = (state_r == OPEN);
      mode_s       = weight_mode_e'(i_weight_mode);
      coord_s      = {CNT_W{1'b0}};
      next_state_s = i_end_of_fig ? IDLE : OPEN;
    end else if (i_data_valid && (state_r == OPEN)) begin
      pix_s        = 1'b1;
      last_s       = i_end_of_fig;
      next_state_s = i_end_of_fig ? IDLE : OPEN;
    end else begin
      next_state_s = state_r;
    end
  end

  // Pixel weight from the figure's latched (or just-sampled) mode.
  always_comb begin
    w_s = WW'(i_data_image);
    case (mode_s)
      WM_SQUARED: w_s = WW'(i_data_image) * WW'(i_data_image);
      WM_LINEAR:  w_s = WW'(i_data_image);
      default:    w_s = WW'(i_data_image);
    endcase
  end

  // FSM state plus per-figure mode and saturating coordinate counter.
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_reset) begin
      state_r <= IDLE;
      mode_r  <= WM_LINEAR;
      coord_r <= {CNT_W{1'b0}};
    end else begin
      state_r <= next_state_s;
      if (pix_s) begin
        mode_r  <= mode_s;
        coord_r <= (coord_s >= CNT_SAT) ? CNT_SAT : coord_s + CNT_W'(1);
      end
    end
  end

  // S1 and S2: register weight/coordinate, then their product.
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_reset) begin
      v1_r  <= 1'b0;
      f1_r  <= 1'b0;
      l1_r  <= 1'b0;
      w1_r  <= {WW{1'b0}};
      c1_r  <= {CNT_W{1'b0}};
      sp1_r <= {COORD_WIDTH{1'b0}};
      v2_r  <= 1'b0;
      f2_r  <= 1'b0;
      l2_r  <= 1'b0;
      w2_r  <= {WW{1'b0}};
      wc2_r <= {SI_W{1'b0}};
      sp2_r <= {COORD_WIDTH{1'b0}};
    end else begin
      v1_r  <= pix_s;
      f1_r  <= first_s;
      l1_r  <= last_s;
      w1_r  <= w_s;
      c1_r  <= coord_s;
      if (first_s) begin
        sp1_r <= i_start_point_value;
      end
      v2_r  <= v1_r;
      f2_r  <= v1_r & f1_r;
      l2_r  <= v1_r & l1_r;
      w2_r  <= w1_r;
      wc2_r <= SI_W'(w1_r) * SI_W'(c1_r);
      sp2_r <= sp1_r;
    end
  end

  // S3: load on the first pixel, add afterwards, stop adding past MAX_PIX.
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_reset) begin
      last3_r   <= 1'b0;
      sum_i3_r  <= {SI_W{1'b0}};
      sum_ic3_r <= {SIC_W{1'b0}};
      cnt3_r    <= {CNT_W{1'b0}};
      sp3_r     <= {COORD_WIDTH{1'b0}};
    end else begin
      last3_r <= v2_r & l2_r;
      if (v2_r && f2_r) begin
        sum_i3_r  <= SI_W'(w2_r);
        sum_ic3_r <= SIC_W'(wc2_r);
        cnt3_r    <= CNT_W'(1);
        sp3_r     <= sp2_r;
      end else if (v2_r && (cnt3_r < CNT_MAX)) begin
        sum_i3_r  <= sum_i3_r + SI_W'(w2_r);
        sum_ic3_r <= sum_ic3_r + SIC_W'(wc2_r);
        cnt3_r    <= cnt3_r + CNT_W'(1);
      end else if (v2_r && (cnt3_r == CNT_MAX)) begin
        cnt3_r    <= CNT_SAT;
      end
    end
  end

  // Size filter, FIFO push request and the drop increment for this cycle.
  always_comb begin
    in_range_s  = (cnt3_r >= CNT_MIN) && (cnt3_r <= CNT_MAX);
    push_req_s  = last3_r & in_range_s;
    full_drop_s = push_req_s & ~can_accept_s;
    s3_drop_s   = last3_r & (~in_range_s | ~can_accept_s);
    drop_inc_s  = {1'b0, abort_s} + {1'b0, s3_drop_s};
    drop_sum_s  = {1'b0, drop_cnt_r} + {15'd0, drop_inc_s};
    res_s.sum_i       = sum_i3_r;
    res_s.sum_i_coord = sum_ic3_r;
    res_s.start_point = sp3_r;
    res_s.pixels      = cnt3_r;
  end

  // Saturating drop counter and sticky FIFO-overflow flag.
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_reset) begin
      drop_cnt_r  <= 16'h0000;
      fifo_drop_r <= 1'b0;
    end else begin
      drop_cnt_r  <= (drop_sum_s > 17'h0FFFF) ? 16'hFFFF : drop_sum_s[15:0];
      fifo_drop_r <= fifo_drop_r | full_drop_s;
    end
  end

  // Side-band delay line matched to end-beat-to-o_res_valid latency.
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_reset) begin
      for (int i = 0; i < 4; i++) begin
        side_r[i] <= {SIDE_WIDTH{1'b0}};
      end
    end else begin
      side_r[0] <= i_side;
      for (int i = 1; i < 4; i++) begin
        side_r[i] <= side_r[i-1];
      end
    end
  end

  cog_result_fifo #(
    .T     (res_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (i_sys_clk),
    .rst        (i_sys_reset),
    .push       (push_req_s),
    .din        (res_s),
    .can_accept (can_accept_s),
    .pop_ready  (i_res_ready),
    .out_valid  (o_res_valid),
    .dout       (fifo_dout_s)
  );

  assign o_res_sum_i       = fifo_dout_s.sum_i;
  assign o_res_sum_i_coord = fifo_dout_s.sum_i_coord;
  assign o_res_start_point = fifo_dout_s.start_point;
  assign o_res_pixels      = fifo_dout_s.pixels;
  assign o_drop_cnt        = drop_cnt_r;
  assign o_fifo_drop       = fifo_drop_r;
  assign o_side            = side_r[3];

endmodule
